// File: rtl/muldiv_unit_if.sv
// Operand, control and HI/LO result bundle shared by the execute-stage controller and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wd,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wd,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide owning HI/LO; one bit per cycle, WIDTH+1 busy cycles then a done pulse.
// busy stalls the controller; start and MTHI/MTLO strobes are ignored while busy.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clock,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               launch;
   logic               is_div_q;
   logic               neg_res;
   logic               neg_rem;
   logic               div_zero;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   logic               signed_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] iter_next;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.a[WIDTH-1];
   assign b_neg     = signed_op & bus.b[WIDTH-1];
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;

   // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb};

   always_comb begin
      iter_next = {mul_sum, acc[WIDTH-1:1]};
      if (is_div_q) begin
         if (div_diff[WIDTH])
            iter_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            iter_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   assign prod_fix = neg_res ? -acc : acc;
   assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (is_div_q) begin
         res_hi = div_zero ? '0 : rem_fix;
         res_lo = div_zero ? '0 : quot_fix;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               launch  = 1'b1;
               state_d = RUN;
            end
         end
         RUN:     if (cnt == '0) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         is_div_q <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         acc      <= '0;
         opb      <= '0;
         cnt      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == FIX);
         if (state_q == IDLE) begin
            if (bus.hi_we) hi_q <= bus.wd;
            if (bus.lo_we) lo_q <= bus.wd;
         end
         if (launch) begin
            is_div_q <= bus.op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (bus.b == '0);
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            opb      <= bus.op[1] ? b_mag : a_mag;
            cnt      <= CW'(WIDTH - 1);
         end else if (state_q == RUN) begin
            acc <= iter_next;
            cnt <= cnt - CW'(1);
         end
         if (state_q == FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
   localparam int W = 32;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   muldiv_unit_if #(.WIDTH(W)) bus();

   muldiv_unit #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: plain signed/unsigned arithmetic with the MIPS divide corner cases
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      longint     sp;
      logic [63:0] p;
      int         sa;
      int         sb;
      h = '0;
      l = '0;
      case (op)
         2'd0: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            h  = p[63:32];
            l  = p[31:0];
         end
         2'd1: begin
            p = {32'd0, a} * {32'd0, b};
            h = p[63:32];
            l = p[31:0];
         end
         2'd2: begin
            if (b == 32'd0) begin
               h = '0; l = '0;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               h = '0; l = 32'h8000_0000;
            end else begin
               sa = $signed(a);
               sb = $signed(b);
               l  = sa / sb;
               h  = sa % sb;
            end
         end
         default: begin
            if (b == 32'd0) begin
               h = '0; l = '0;
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endfunction

   // Launch one operation from IDLE at a negedge, scramble inputs after launch, and check timing and result.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [31:0] exp_hi, exp_lo, prev_hi, prev_lo;
      int busy_n;
      bit held, got;
      model(op, a, b, exp_hi, exp_lo);
      prev_hi   = bus.hi;
      prev_lo   = bus.lo;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clock);
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
      busy_n = 0;
      held   = 1'b1;
      got    = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (bus.done === 1'b1) got = 1'b1;
         else begin
            if (bus.busy === 1'b1) busy_n++;
            if (bus.hi !== prev_hi || bus.lo !== prev_lo) held = 1'b0;
            @(negedge clock);
         end
      end
      checks++;
      if (!got) begin failures++; $display("FAIL %s done: no done pulse within 40 cycles", name); end
      checks++;
      if (busy_n !== W + 1) begin failures++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, W + 1); end
      checks++;
      if (!held) begin failures++; $display("FAIL %s hold: hi/lo changed while busy (want %h/%h)", name, prev_hi, prev_lo); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s busy_in_done: got %b want 0", name, bus.busy); end
      checks++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
         failures++;
         $display("FAIL %s result: op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                  name, op, a, b, bus.hi, bus.lo, exp_hi, exp_lo);
      end
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL %s done_width: got %b want 0", name, bus.done); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl: busy=%b done=%b want 0/0", bus.busy, bus.done);
      end
      checks++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         failures++; $display("FAIL reset_hilo: hi=%h lo=%h want 0/0", bus.hi, bus.lo);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_mult();
      do_op(2'd0, 32'd7, 32'hFFFF_FFFD, "mult_7x-3");
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1");
   endtask

   task automatic test_div();
      do_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
      do_op(2'd3, 32'd100, 32'd7, "divu_100/7");
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
   endtask

   task automatic test_div_zero();
      do_op(2'd3, 32'd100, 32'd0, "divu_by_zero");
      do_op(2'd2, 32'hFFFF_FF00, 32'd0, "div_by_zero");
   endtask

   task automatic test_busy_inputs();
      logic [31:0] prev_hi, r_hi, r_lo;
      int dones;
      bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd3; bus.b = 32'd5;
      @(negedge clock);
      bus.start = 1'b0;
      prev_hi = bus.hi;
      dones = 0;
      r_hi = '1;
      r_lo = '1;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         if (bus.done === 1'b1) begin dones++; r_hi = bus.hi; r_lo = bus.lo; end
         if (cyc == 13) begin
            checks++;
            if (bus.hi !== prev_hi) begin
               failures++; $display("FAIL busy_mthi_ignored: hi=%h want %h", bus.hi, prev_hi);
            end
         end
         bus.start = (cyc == 10);
         bus.op    = (cyc == 10) ? 2'd2 : 2'd1;
         bus.a     = (cyc == 10) ? 32'd77 : 32'd3;
         bus.b     = (cyc == 10) ? 32'd0 : 32'd5;
         bus.hi_we = (cyc == 12);
         bus.wd    = 32'hDEAD;
         @(negedge clock);
      end
      checks++;
      if (dones !== 1) begin failures++; $display("FAIL busy_single_done: got %0d pulses want 1", dones); end
      checks++;
      if (r_hi !== 32'd0 || r_lo !== 32'd15) begin
         failures++; $display("FAIL busy_result: hi=%h lo=%h want 0/f", r_hi, r_lo);
      end
      bus.lo_we = 1'b1;
      bus.wd    = 32'd9;
      @(negedge clock);
      bus.lo_we = 1'b0;
      checks++;
      if (bus.lo !== 32'd9 || bus.hi !== 32'd0) begin
         failures++; $display("FAIL mtlo_idle: hi=%h lo=%h want 0/9", bus.hi, bus.lo);
      end
   endtask

   task automatic test_mt_write();
      bit got;
      bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd2;
      bus.hi_we = 1'b1; bus.wd = 32'h1234;
      @(negedge clock);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      checks++;
      if (bus.hi !== 32'h1234) begin failures++; $display("FAIL mthi_with_start: hi=%h want 1234", bus.hi); end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (bus.done === 1'b1) got = 1'b1;
         else @(negedge clock);
      end
      checks++;
      if (!got || bus.hi !== 32'd0 || bus.lo !== 32'd4) begin
         failures++; $display("FAIL mt_overwrite: done=%b hi=%h lo=%h want 1/0/4", got, bus.hi, bus.lo);
      end
      bus.lo_we = 1'b1;
      bus.wd    = 32'h55;
      @(negedge clock);
      bus.lo_we = 1'b0;
      checks++;
      if (bus.lo !== 32'h55) begin failures++; $display("FAIL mtlo_done_cycle: lo=%h want 55", bus.lo); end
   endtask

   task automatic test_reset_mid_op();
      int dones;
      bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd100; bus.b = 32'd7;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (14) @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         failures++; $display("FAIL reset_mid_op: busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
      end
      @(negedge clock);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
         @(negedge clock);
      end
      checks++;
      if (dones !== 0) begin failures++; $display("FAIL reset_no_done: %0d busy/done cycles want 0", dones); end
      do_op(2'd0, 32'd2, 32'd3, "mult_after_reset");
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(1, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      for (int n = 0; n < 24; n++)
         do_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), "random");
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wd    = '0;
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_busy_inputs();
      test_mt_write();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
